// File: rtl/bus_grant_arbiter.sv
// bus_grant_arbiter
//   Round-robin arbiter for the shared 32-bit internal bus. One of 32 drivers
//   is granted at a time. The grant is registered and one-hot, and a matching
//   5-bit select code is provided. There is always one idle cycle (grant = 0)
//   between two grants.
//
// Optional build macro:
//   BUS_ARB_HOLD_LIMIT_EN - when defined, the owner is forced off the bus after
//                           MAX_HOLD consecutive grant cycles.
//
// Ports:
//   clock_i       system clock, rising edge
//   clear_i       synchronous active-high reset
//   arb_en_i      permits new grants; does not affect an existing grant
//   req_i[31:0]   per-driver bus request
//   grant_o[31:0] registered one-hot grant, zero when idle
//   grant_code_o  binary index of the granted driver, zero when idle
//   busy_o        high while a grant is active
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no grant; arbitrate when arb_en_i and any req
// OWN   | one driver holds the bus until it releases
module bus_grant_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic        clock_i,
  input  logic        clear_i,
  input  logic        arb_en_i,
  input  logic [31:0] req_i,
  output logic [31:0] grant_o,
  output logic [4:0]  grant_code_o,
  output logic        busy_o
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;

  if (MAX_HOLD < 1 || MAX_HOLD > 255 || (64'd1 << HOLD_W) <= 64'(MAX_HOLD)) begin : g_bad_param
    $error("bus_grant_arbiter: MAX_HOLD/HOLD_W out of range");
  end

  logic        state_q, state_d;
  logic [31:0] grant_q, grant_d;
  logic [4:0]  code_q, code_d;
  logic [4:0]  rr_ptr_q, rr_ptr_d;

  logic        win_found;
  logic [4:0]  win_idx;
  logic [4:0]  cand;
  logic        release_own;

`ifdef BUS_ARB_HOLD_LIMIT_EN
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              hold_done;
  assign hold_done   = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
  assign release_own = ~req_i[code_q] | hold_done;
`else
  assign release_own = ~req_i[code_q];
`endif

  // Search from rr_ptr upward with wrap; scanning the offsets downward lets
  // the smallest offset overwrite the others and win.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 31; i >= 0; i--) begin
      cand = rr_ptr_q + 5'(i);
      if (req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    code_d   = code_q;
    rr_ptr_d = rr_ptr_q;
`ifdef BUS_ARB_HOLD_LIMIT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    if (state_q == ST_IDLE) begin
      if (arb_en_i && win_found) begin
        state_d = ST_OWN;
        grant_d = 32'd1 << win_idx;
        code_d  = win_idx;
`ifdef BUS_ARB_HOLD_LIMIT_EN
        hold_cnt_d = '0;
`endif
      end
    end else begin
      if (release_own) begin
        // Returning to IDLE for a cycle guarantees the bus turnaround.
        state_d  = ST_IDLE;
        grant_d  = '0;
        code_d   = '0;
        rr_ptr_d = code_q + 5'd1;
      end
`ifdef BUS_ARB_HOLD_LIMIT_EN
      else if (hold_cnt_q != '1) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      code_q   <= '0;
      rr_ptr_q <= '0;
`ifdef BUS_ARB_HOLD_LIMIT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      code_q   <= code_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef BUS_ARB_HOLD_LIMIT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign grant_o      = grant_q;
  assign grant_code_o = code_q;
  assign busy_o       = (state_q == ST_OWN);

endmodule

// File: tb/tb_bus_grant_arbiter.sv
module tb_bus_grant_arbiter;

  localparam int MAX_HOLD = 4;

  logic        clock;
  logic        clear;
  logic        arb_en;
  logic [31:0] req;
  logic [31:0] grant;
  logic [4:0]  grant_code;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  // reference model: owner index (-1 = idle), round-robin start, cycles held
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;

  bus_grant_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (
    .clock_i      (clock),
    .clear_i      (clear),
    .arb_en_i     (arb_en),
    .req_i        (req),
    .grant_o      (grant),
    .grant_code_o (grant_code),
    .busy_o       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        clr;
    logic        en;
    logic [31:0] rq;
    logic [31:0] eg;
    logic [4:0]  ec;
    logic        eb;
  } vec_t;

  vec_t tbl[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step(input logic c, input logic e, input logic [31:0] r);
    bit rel;
    if (c) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      if (e && r != 0) begin
        for (int k = 0; k < 32; k++) begin
          if (r[(m_ptr + k) % 32]) begin
            m_owner = (m_ptr + k) % 32;
            break;
          end
        end
        m_held = 1;
      end
    end else begin
      rel = !r[m_owner];
`ifdef BUS_ARB_HOLD_LIMIT_EN
      if (m_held == MAX_HOLD) rel = 1'b1;
`endif
      if (rel) begin
        m_ptr   = (m_owner + 1) % 32;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  // Apply inputs, clock once, update model, sample on the falling edge.
  task automatic cycle(input logic c, input logic e, input logic [31:0] r);
    clear  = c;
    arb_en = e;
    req    = r;
    @(posedge clock);
    model_step(c, e, r);
    @(negedge clock);
  endtask

  task automatic check_model(input string tag);
    logic [31:0] eg;
    logic [4:0]  ec;
    int          o;
    o  = m_owner;
    eg = (o < 0) ? 32'd0 : (32'd1 << o);
    ec = (o < 0) ? 5'd0 : 5'(o);
    check({tag, ".grant"}, grant, eg);
    check({tag, ".code"}, {27'd0, grant_code}, {27'd0, ec});
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, o >= 0});
    check({tag, ".onehot"}, {31'd0, $countones(grant) <= 1}, 32'd1);
  endtask

  task automatic expect_code(input string tag, input int code);
    check({tag, ".grant"}, grant, (code < 0) ? 32'd0 : (32'd1 << code));
    check({tag, ".code"}, {27'd0, grant_code}, (code < 0) ? 32'd0 : 32'(code));
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, code >= 0});
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    logic        c;
    int          exp_code;

    clear  = 1'b1;
    arb_en = 1'b0;
    req    = '0;

    tbl[0]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 5'd0,  1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_0010, 5'd4,  1'b1};
    tbl[2]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 5'd0,  1'b0};
    tbl[3]  = '{1'b0, 1'b1, 32'h0000_0011, 32'h0000_0001, 5'd0,  1'b1}; // ptr=5 skips bit 4
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 5'd0,  1'b0};
    tbl[5]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_0010, 5'd4,  1'b1};
    tbl[6]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 5'd0,  1'b0};
    tbl[7]  = '{1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd31, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 32'h0000_0003, 32'h0000_0000, 5'd0,  1'b0};
    tbl[9]  = '{1'b0, 1'b1, 32'h0000_0003, 32'h0000_0001, 5'd0,  1'b1}; // ptr wrapped to 0
    tbl[10] = '{1'b0, 1'b1, 32'h0000_0002, 32'h0000_0000, 5'd0,  1'b0};
    tbl[11] = '{1'b0, 1'b1, 32'h0000_0002, 32'h0000_0002, 5'd1,  1'b1};
    tbl[12] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 5'd0,  1'b0};
    tbl[13] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 5'd0,  1'b0};
    tbl[14] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 5'd0,  1'b0};
    tbl[15] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0000_0100, 5'd8,  1'b1};
    tbl[16] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0000_0100, 5'd8,  1'b1};
    tbl[17] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd0,  1'b0};
    tbl[18] = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_1000, 5'd12, 1'b1};
    tbl[19] = '{1'b1, 1'b1, 32'h0000_1000, 32'h0000_0000, 5'd0,  1'b0};
    tbl[20] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  1'b1};
    tbl[21] = '{1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0000, 5'd0,  1'b0};
    tbl[22] = '{1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0002, 5'd1,  1'b1};

    for (int i = 0; i < 23; i++) begin
      cycle(tbl[i].clr, tbl[i].en, tbl[i].rq);
      check($sformatf("tbl%0d.grant", i), grant, tbl[i].eg);
      check($sformatf("tbl%0d.code", i), {27'd0, grant_code}, {27'd0, tbl[i].ec});
      check($sformatf("tbl%0d.busy", i), {31'd0, busy}, {31'd0, tbl[i].eb});
    end

    // Alternation between drivers 0 and 31, each holding two cycles.
    cycle(1'b1, 1'b1, 32'h0);
    cycle(1'b0, 1'b1, 32'h8000_0001); expect_code("alt0", 0);
    cycle(1'b0, 1'b1, 32'h8000_0001); expect_code("alt1", 0);
    cycle(1'b0, 1'b1, 32'h8000_0000); expect_code("alt2", -1);
    cycle(1'b0, 1'b1, 32'h8000_0001); expect_code("alt3", 31);
    cycle(1'b0, 1'b1, 32'h8000_0001); expect_code("alt4", 31);
    cycle(1'b0, 1'b1, 32'h0000_0001); expect_code("alt5", -1);
    cycle(1'b0, 1'b1, 32'h8000_0001); expect_code("alt6", 0);

    // Constant requests from drivers 1 and 2: hold limit behaviour.
    cycle(1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, 1'b1, 32'h0000_0006);
`ifdef BUS_ARB_HOLD_LIMIT_EN
      case (i % 10)
        4, 9:    exp_code = -1;
        5, 6, 7, 8: exp_code = 2;
        default: exp_code = 1;
      endcase
`else
      exp_code = 1;
`endif
      expect_code($sformatf("hold%0d", i), exp_code);
    end

    // Randomized traffic against the reference model.
    cycle(1'b1, 1'b1, 32'h0);
    check_model("rst");
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) r = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 15) == 0) r = '0;
      e = ($urandom_range(0, 7) != 0);
      c = ($urandom_range(0, 199) == 0);
      cycle(c, e, r);
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_grant_arbiter.md
Name: bus_grant_arbiter

Overview:
- Round-robin arbiter sharing the single 32-bit internal bus among 32 register/unit drivers.
- Takes per-driver bus requests and issues a registered one-hot grant; the grant vector drives the bus-select encoder directly.
- Also outputs the matching 5-bit select code, so the downstream encoder never sees zero-hot or multi-hot input.
- Sits between the control unit's out-enable requests and the bus mux.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one driver may hold the grant (used only with the optional feature); legal range 1..255.
- HOLD_W, 8, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  synchronous, active-high reset.
- arb_en  in  1  when low, no new grant is issued; an existing grant continues normally.
- req  in  32  bus request, one bit per driver; bit i = driver i.
- grant  out  32  registered one-hot bus grant; all-zero when the bus is idle.
- grant_code  out  5  binary index of the granted driver; 0 when idle.
- busy  out  1  high while any grant bit is high.

Behaviour:
- Reset (clear=1 at a clock edge): grant=0, grant_code=0, busy=0, state=IDLE, rr_ptr=0, hold_cnt=0. Reset overrides everything, including mid-grant; the grant drops on the same edge.
- State machine has two states: IDLE and OWN.
- IDLE, arb_en=1, req!=0:
  - Choose the winner w = first index with req set, searching rr_ptr, rr_ptr+1, ..., wrapping 31 to 0.
  - Next edge: grant=1<<w, grant_code=w, busy=1, hold_cnt=0, state=OWN.
  - Latency from req rising to grant is exactly 1 cycle.
- IDLE, arb_en=0 or req=0: outputs stay zero.
- OWN: release condition = req[owner]==0 (or hold limit reached, see Optional Feature).
  - On release at the next edge: grant=0, grant_code=0, busy=0, rr_ptr=(owner+1) mod 32, state=IDLE.
  - Otherwise hold_cnt increments (saturating at its maximum) and the grant is unchanged.
- There is a mandatory one-cycle turnaround (grant=0) between any two grants, so two drivers never overlap on the bus.
- grant is always zero-hot or one-hot. grant_code always equals the index of the set bit.
- The pointer wraps: owner 31 releases, so rr_ptr becomes 0.
- Requests from non-owners during OWN are ignored until IDLE. A request present at IDLE is granted with no memory of its earlier assertion.
- Simultaneous events:
  - owner drops req in the same cycle another driver raises req: release first, the new driver is granted after the turnaround cycle.
  - arb_en falls during OWN: no effect on the current grant; the next grant waits for arb_en=1.
- Single requester re-requesting: still gets the grant again after the turnaround, because the search wraps back to it.

Optional Feature:
- Macro: BUS_ARB_HOLD_LIMIT_EN.
- Defined:
  - OWN also releases when hold_cnt == MAX_HOLD-1, i.e. after MAX_HOLD grant cycles, even if req[owner] is still high.
  - rr_ptr advances past the owner as normal.
  - The same driver may be re-granted only if no other driver requests.
- Not defined:
  - No hold counter logic is synthesised.
  - The grant is held until req[owner] drops; MAX_HOLD and HOLD_W are ignored.

Test Plan:
- Reset, then req=32'h0000_0010 at cycle 0 -> cycle 1: grant=32'h0000_0010, grant_code=4, busy=1. Drop req -> next cycle grant=0, rr_ptr=5.
- req=32'h8000_0001 held, each winner drops req after 2 grant cycles, then re-asserts -> grants alternate: code 0, idle, code 31, idle, code 0. There is never a cycle with two grant bits set.
- Owner 31 releases with req=32'h0000_0003 -> rr_ptr wraps to 0, next grant code 0, then after it releases code 1.
- arb_en=0 with req=32'h0000_0100 -> grant stays 0. Raise arb_en -> grant code 8 one cycle later. Lower arb_en mid-grant -> grant persists until req[8] drops.
- clear=1 asserted during OWN with grant code 12 -> next edge grant=0, grant_code=0, busy=0. After clear releases, req=32'hFFFF_FFFF -> first grant code 0.
- With BUS_ARB_HOLD_LIMIT_EN and MAX_HOLD=4, req=32'h0000_0006 held constant -> code 1 for 4 cycles, 1 idle, code 2 for 4 cycles, 1 idle, code 1. Without the macro -> code 1 is held indefinitely.
